// File: rtl/sev_seg_decoder.sv
// Snooping decoder for the stopwatch's four-digit seven-segment bus. It waits for a
// stable frame, decodes it back to BCD seconds, and flags illegal frames and bad steps.
module sev_seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] HEX [0:3],
  input  logic       clr_err,
  output logic [2:0] tens_sec,
  output logic [3:0] ones_sec,
  output logic [3:0] tenth_sec,
  output logic       valid,
  output logic       update,
  output logic       seq_err,
  output logic       err
);

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } digit_t;

  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] SEG_DOT   = 8'h7F;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low patterns with the DP bit off; anything else is not a digit.
  function automatic digit_t seg_decode(input logic [7:0] seg);
    digit_t d;
    d.ok  = 1'b1;
    d.val = 4'd0;
    case (seg)
      8'hC0:   d.val = 4'd0;
      8'hF9:   d.val = 4'd1;
      8'hA4:   d.val = 4'd2;
      8'hB0:   d.val = 4'd3;
      8'h99:   d.val = 4'd4;
      8'h92:   d.val = 4'd5;
      8'h82:   d.val = 4'd6;
      8'hF8:   d.val = 4'd7;
      8'h80:   d.val = 4'd8;
      8'h90:   d.val = 4'd9;
      default: d.ok  = 1'b0;
    endcase
    return d;
  endfunction

  logic [7:0] r_s_q [0:3];
  logic [7:0] r_stab_cnt;
  state_t     r_state;
  logic [2:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] r_tenth;
  logic       r_valid;
  logic       r_update;
  logic       r_seq_err;
  logic       r_err;

  logic       w_changed;
  digit_t     w_tens;
  digit_t     w_ones;
  digit_t     w_tenth;
  logic       w_legal;
  logic       w_same;
  logic       w_is_zero;
  logic       w_is_step;
  logic [2:0] w_exp_tens;
  logic [3:0] w_exp_ones;
  logic [3:0] w_exp_tenth;

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_changed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (HEX[i] != r_s_q[i]) w_changed = 1'b1;
    end
  end

  always_comb begin
    w_tens    = seg_decode(r_s_q[3]);
    w_ones    = seg_decode(r_s_q[2]);
    w_tenth   = seg_decode(r_s_q[0]);
    w_legal   = w_tens.ok && (w_tens.val <= 4'd5) && w_ones.ok && w_tenth.ok &&
                (r_s_q[1] == SEG_DOT);
    w_same    = (w_tens.val[2:0] == r_tens) && (w_ones.val == r_ones) &&
                (w_tenth.val == r_tenth);
    w_is_zero = (w_tens.val == 4'd0) && (w_ones.val == 4'd0) && (w_tenth.val == 4'd0);
    w_is_step = (w_tens.val[2:0] == w_exp_tens) && (w_ones.val == w_exp_ones) &&
                (w_tenth.val == w_exp_tenth);
  end

  // Held value plus 0.1 s, wrapping 59.9 back to 00.0.
  always_comb begin
    w_exp_tens  = r_tens;
    w_exp_ones  = r_ones;
    w_exp_tenth = r_tenth + 4'd1;
    if (r_tenth == 4'd9) begin
      w_exp_tenth = 4'd0;
      w_exp_ones  = r_ones + 4'd1;
      if (r_ones == 4'd9) begin
        w_exp_ones = 4'd0;
        w_exp_tens = (r_tens == 3'd5) ? 3'd0 : r_tens + 3'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sample register is a handful of flops, not a memory; it is reset
      // to blank so the first real frame always reads as a change.
      for (int i = 0; i < 4; i++) r_s_q[i] <= SEG_BLANK;
      r_stab_cnt <= 8'd0;
      r_state    <= ST_WAIT;
      r_tens     <= 3'd0;
      r_ones     <= 4'd0;
      r_tenth    <= 4'd0;
      r_valid    <= 1'b0;
      r_update   <= 1'b0;
      r_seq_err  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) r_s_q[i] <= HEX[i];

      if (w_changed) begin
        r_stab_cnt <= 8'd1;
      end else if (r_stab_cnt < STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + 8'd1;
      end

      r_update  <= 1'b0;
      r_seq_err <= 1'b0;
      // A set below overrides this clear when both happen in the same cycle.
      if (clr_err) r_err <= 1'b0;

      case (r_state)
        ST_WAIT: begin
          if (r_stab_cnt == STAB_MAX) begin
            if (w_legal) begin
              r_tens  <= w_tens.val[2:0];
              r_ones  <= w_ones.val;
              r_tenth <= w_tenth.val;
              r_valid <= 1'b1;
              if (!r_valid || !w_same) begin
                r_update  <= 1'b1;
                r_seq_err <= r_valid && !w_is_zero && !w_is_step;
              end
            end else begin
              r_valid <= 1'b0;
              r_err   <= 1'b1;
            end
            // A frame change on the accept edge starts a fresh count.
            if (!w_changed) r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_changed) r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign tens_sec  = r_tens;
  assign ones_sec  = r_ones;
  assign tenth_sec = r_tenth;
  assign valid     = r_valid;
  assign update    = r_update;
  assign seq_err   = r_seq_err;
  assign err       = r_err;

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Bench for sev_seg_decoder: latency and reset sequences, a vector table of stopwatch
// scenarios, and randomized frames compared every cycle against a time-domain model.
module tb_sev_seg_decoder;

  localparam int STABLE = 4;

  typedef logic [31:0] frame_t;  // {HEX[3], HEX[2], HEX[1], HEX[0]}

  typedef struct {
    frame_t f;
    int     hold;
    int     clr_at;
    int     exp_t;
    bit     exp_valid;
    bit     exp_err;
    int     exp_upd;
    int     exp_seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] hex [0:3];
  logic       clr_err;

  logic [2:0] tens0, tens1;
  logic [3:0] ones0, ones1, tenth0, tenth1;
  logic       valid0, valid1, upd0, upd1, seq0, seq1, err0, err1;

  sev_seg_decoder #(.STABLE_CYCLES(STABLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .HEX(hex), .clr_err(clr_err),
    .tens_sec(tens0), .ones_sec(ones0), .tenth_sec(tenth0),
    .valid(valid0), .update(upd0), .seq_err(seq0), .err(err0)
  );

  sev_seg_decoder #(.STABLE_CYCLES(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .HEX(hex), .clr_err(clr_err),
    .tens_sec(tens1), .ones_sec(ones1), .tenth_sec(tenth1),
    .valid(valid1), .update(upd1), .seq_err(seq1), .err(err1)
  );

  always #5 clk = ~clk;

  logic [7:0] pat [0:9];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time held in tenths of a second, plus the sample history.
  frame_t hist [$];
  int     m_t;
  bit     m_valid, m_upd, m_seq, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input int t);
    return {pat[t / 100], pat[(t / 10) % 10], 8'h7F, pat[t % 10]};
  endfunction

  function automatic bit decode(input frame_t f, output int t);
    int d [4];
    bit ok [4];
    for (int i = 0; i < 4; i++) begin
      ok[i] = 1'b0;
      d[i]  = 0;
      for (int v = 0; v < 10; v++) begin
        if (f[8*i +: 8] == pat[v]) begin
          ok[i] = 1'b1;
          d[i]  = v;
        end
      end
    end
    t = d[3] * 100 + d[2] * 10 + d[0];
    return ok[3] && (d[3] <= 5) && ok[2] && ok[0] && (f[15:8] == 8'h7F);
  endfunction

  // True when the last STABLE samples form a run of exactly STABLE identical frames.
  function automatic bit run_complete();
    int n;
    n = hist.size();
    if (n < STABLE) return 1'b0;
    for (int i = n - STABLE; i < n; i++) begin
      if (hist[i] != hist[n-1]) return 1'b0;
    end
    return (n == STABLE) || (hist[n-STABLE-1] != hist[n-1]);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_t = 0;
    m_valid = 1'b0;
    m_upd = 1'b0;
    m_seq = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_edge(input frame_t f, input bit clr);
    bit acc;
    bit ok;
    int t;
    ok  = 1'b1;
    t   = 0;
    acc = run_complete();
    m_upd = 1'b0;
    m_seq = 1'b0;
    if (acc) begin
      ok = decode(hist[hist.size()-1], t);
      if (ok) begin
        if (!m_valid || t != m_t) begin
          m_upd = 1'b1;
          m_seq = m_valid && (t != 0) && (t != (m_t + 1) % 600);
        end
        m_t = t;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (acc && !ok) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    hist.push_back(f);
    if (hist.size() > STABLE + 1) void'(hist.pop_front());
  endtask

  task automatic tick(input frame_t f, input bit clr);
    for (int i = 0; i < 4; i++) hex[i] = f[8*i +: 8];
    clr_err = clr;
    @(posedge clk);
    model_edge(f, clr);
    #1;
  endtask

  function automatic logic [14:0] vec0();
    return {tens0, ones0, tenth0, valid0, upd0, seq0, err0};
  endfunction

  function automatic logic [14:0] vec1();
    return {tens1, ones1, tenth1, valid1, upd1, seq1, err1};
  endfunction

  function automatic logic [14:0] model_vec();
    return {3'(m_t / 100), 4'((m_t / 10) % 10), 4'(m_t % 10), m_valid, m_upd, m_seq, m_err};
  endfunction

  function automatic vec_t mv(input frame_t f, input int hold, input int clr_at, input int t,
                              input bit v, input bit e, input int u, input int s);
    vec_t r;
    r.f = f; r.hold = hold; r.clr_at = clr_at; r.exp_t = t;
    r.exp_valid = v; r.exp_err = e; r.exp_upd = u; r.exp_seq = s;
    return r;
  endfunction

  vec_t vecs [$];

  initial begin
    int nu, ns, r, hold, nt, last, p;
    frame_t f;

    pat[0] = 8'hC0; pat[1] = 8'hF9; pat[2] = 8'hA4; pat[3] = 8'hB0; pat[4] = 8'h99;
    pat[5] = 8'h92; pat[6] = 8'h82; pat[7] = 8'hF8; pat[8] = 8'h80; pat[9] = 8'h90;

    //            frame                         hold clr  t   v  e  upd seq
    vecs.push_back(mv(mk(598),                   10, -1, 598, 1, 0, 1, 1));
    vecs.push_back(mv(mk(599),                   10, -1, 599, 1, 0, 1, 0));
    vecs.push_back(mv(mk(0),                     10, -1,   0, 1, 0, 1, 0));
    vecs.push_back(mv(mk(2),                     10, -1,   2, 1, 0, 1, 1));
    vecs.push_back(mv(mk(12),                    10, -1,  12, 1, 0, 1, 1));
    vecs.push_back(mv(mk(13),                     3, -1,  12, 1, 0, 0, 0));
    vecs.push_back(mv(mk(12),                    10, -1,  12, 1, 0, 0, 0));
    vecs.push_back(mv(mk(13),                    10, -1,  13, 1, 0, 1, 0));
    vecs.push_back(mv({8'hC0, 8'hF9, 8'h7F, 8'hBF}, 10, -1, 13, 0, 1, 0, 0));
    vecs.push_back(mv(mk(13),                    10,  0,  13, 1, 0, 1, 0));
    vecs.push_back(mv({8'hC0, 8'hF9, 8'hFF, 8'hC0}, 10,  4, 13, 0, 1, 0, 0));
    vecs.push_back(mv(mk(411),                   10, -1, 411, 1, 1, 1, 0));
    vecs.push_back(mv(mk(412),                   10, -1, 412, 1, 1, 1, 0));
    vecs.push_back(mv(mk(812),                   10, -1, 412, 0, 1, 0, 0));
    vecs.push_back(mv(mk(55),                    10, -1,  55, 1, 1, 1, 0));
    vecs.push_back(mv(mk(56),                    10,  0,  56, 1, 0, 1, 0));
    vecs.push_back(mv(mk(333),                   10, -1, 333, 1, 0, 1, 1));
    vecs.push_back(mv(mk(0),                     10, -1,   0, 1, 0, 1, 0));
    vecs.push_back(mv(mk(99),                    10, -1,  99, 1, 0, 1, 1));
    vecs.push_back(mv(mk(100),                   10, -1, 100, 1, 0, 1, 0));

    // Reset with 01.2 already on the bus; check first-accept latency on both instances.
    rst_n = 1'b0;
    clr_err = 1'b0;
    f = mk(12);
    for (int i = 0; i < 4; i++) hex[i] = f[8*i +: 8];
    model_reset();
    #1;
    check("reset outputs", 32'(vec0()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(mk(12), 1'b0);
      check($sformatf("latency s4 edge%0d", e), 32'(vec0()),
            (e < 5) ? 32'd0 : 32'({3'd0, 4'd1, 4'd2, 1'b1, (e == 5), 1'b0, 1'b0}));
      check($sformatf("latency s1 edge%0d", e), 32'(vec1()),
            (e < 2) ? 32'd0 : 32'({3'd0, 4'd1, 4'd2, 1'b1, (e == 2), 1'b0, 1'b0}));
    end

    foreach (vecs[i]) begin
      nu = 0;
      ns = 0;
      for (int c = 0; c < vecs[i].hold; c++) begin
        tick(vecs[i].f, c == vecs[i].clr_at);
        nu += int'(upd0);
        ns += int'(seq0);
      end
      check($sformatf("vec%0d time", i),
            32'(int'(tens0) * 100 + int'(ones0) * 10 + int'(tenth0)), 32'(vecs[i].exp_t));
      check($sformatf("vec%0d valid", i), 32'(valid0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d err", i), 32'(err0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d updates", i), 32'(nu), 32'(vecs[i].exp_upd));
      check($sformatf("vec%0d seq_errs", i), 32'(ns), 32'(vecs[i].exp_seq));
    end

    // Reset in the middle of counting a new frame: outputs clear at once.
    tick(mk(222), 1'b0);
    tick(mk(222), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid reset s4", 32'(vec0()), 32'd0);
    check("mid reset s1", 32'(vec1()), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(mk(222), 1'b0);
      check($sformatf("after reset edge%0d", e), 32'(vec0()),
            (e < 5) ? 32'd0 : 32'({3'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0}));
    end

    // Randomized frames and hold times, compared every cycle with the model.
    last = 222;
    for (int n = 0; n < 300; n++) begin
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 8);
      if (r < 45)      nt = (last + 1) % 600;
      else if (r < 55) nt = 0;
      else if (r < 65) nt = last;
      else             nt = $urandom_range(0, 599);
      f = mk(nt);
      if (r >= 88) begin
        p = $urandom_range(0, 3);
        f[8*p +: 8] = 8'($urandom);
      end
      last = nt;
      for (int c = 0; c < hold; c++) begin
        tick(f, $urandom_range(0, 15) == 0);
        check("random vs model", 32'(vec0()), 32'(model_vec()));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
